// File: rtl/seq_tx_pkg.sv
// Shared types and default target sequence for the pattern transmitter and
// the detector benches that reuse its reference tracker.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } tx_state_t;

  localparam int DEF_PAT_W = 4;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1101;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Parallel word handshake into the pattern transmitter.
interface seq_pattern_tx_if #(
  parameter int WORD_W = 8
);
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/seq_match_tracker.sv
// Golden Moore-detector model: samples the serial line every cycle and flags
// the cycle after the target sequence completes, with a saturating hit count.
module seq_match_tracker
  import seq_tx_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int               CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             cnt_clr,
  output logic             exp_detect,
  output logic [CNT_W-1:0] det_count
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  history_q, history_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Until PAT_W bits have been seen, the zeroed history must not alias a pattern of zeros.
  assign exp_detect = (fill_q == FILL_FULL) && (history_q == PATTERN);
  assign det_count  = count_q;

  always_comb begin
    history_d = PAT_W'({history_q, bit_in});
    fill_d    = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    count_d   = count_q;
    if (cnt_clr) begin
      count_d = '0;
    end else if (exp_detect && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      history_q <= '0;
      fill_q    <= '0;
      count_q   <= '0;
    end else begin
      history_q <= history_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: rtl/seq_pattern_tx.sv
// MSB-first serializer with programmable inter-word gap, driving a detector's
// input line and carrying the reference model of that detector.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int               WORD_W     = 8,
  parameter int               PAT_W      = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN    = DEF_PATTERN,
  parameter int               GAP_CYCLES = 2,
  parameter logic             IDLE_BIT   = 1'b0,
  parameter int               CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  seq_pattern_tx_if.slave  bus,
  input  logic             cnt_clr,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             exp_detect,
  output logic [CNT_W-1:0] det_count
);

  localparam int BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int GAPC_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BIT_W-1:0]  BIT_TOP = BIT_W'(WORD_W - 1);
  localparam logic [GAPC_W-1:0] GAP_TOP = GAPC_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  tx_state_t         state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d, shreg_adv;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GAPC_W-1:0] gap_cnt_q, gap_cnt_d;
  logic              ser_out_q, ser_out_d;
  logic              ser_valid_q, ser_valid_d;
  logic              frame_start_q, frame_start_d;
  logic              word_end, ready, take;

  // The final cycle of a word is the last gap cycle, or the last bit when there is no gap.
  always_comb begin
    word_end = ((state_q == SHIFT) && (bit_cnt_q == '0) && (GAP_CYCLES == 0))
            || ((state_q == GAP) && (gap_cnt_q == '0));
    ready    = !reset && ((state_q == IDLE) || word_end);
    take     = ready && bus.in_valid;
  end

  assign bus.in_ready = ready;

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    ser_out_d     = IDLE_BIT;
    ser_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    shreg_adv     = shreg_q << 1;

    case (state_q)
      IDLE: ;
      SHIFT: begin
        if (bit_cnt_q != '0) begin
          shreg_d     = shreg_adv;
          bit_cnt_d   = bit_cnt_q - BIT_W'(1);
          ser_out_d   = shreg_adv[WORD_W-1];
          ser_valid_d = 1'b1;
        end else if (GAP_CYCLES > 0) begin
          state_d   = GAP;
          gap_cnt_d = GAP_TOP;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - GAPC_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The MSB goes straight onto the line at the accepting edge.
    if (take) begin
      state_d       = SHIFT;
      shreg_d       = bus.in_data;
      bit_cnt_d     = BIT_TOP;
      ser_out_d     = bus.in_data[WORD_W-1];
      ser_valid_d   = 1'b1;
      frame_start_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      ser_out_q     <= IDLE_BIT;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = (state_q != IDLE);

  seq_match_tracker #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .CNT_W   (CNT_W)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .bit_in     (ser_out_q),
    .cnt_clr    (cnt_clr),
    .exp_detect (exp_detect),
    .det_count  (det_count)
  );

endmodule
